// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, single-outstanding imem req/gnt/rvalid, 2-entry {pc,inst} FIFO.
// Define INST_FETCH_PERF_EN to add fetch/flush/bubble performance counters.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
`ifdef INST_FETCH_PERF_EN
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_cnt_o,
  output logic [31:0]       bubble_cnt_o,
`endif
  output logic              inst_valid_o
);

  typedef enum logic [1:0] {ISSUE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] fetch_pc_q, req_pc_q, last_pc_q, redirect_pc;
  logic [ADDR_W-1:0] fifo_pc [2];
  logic [31:0]       fifo_inst [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;
  logic              empty, fire, push, pop;

  assign redirect_pc = redirect_pc_i & ~ADDR_W'(3);
  assign empty       = (count_q == 2'd0);
  assign fire        = imem_req_o & imem_gnt_i;
  // A response is kept only in WAIT and only if no redirect coincides with it.
  assign push        = (state_q == WAIT) & imem_rvalid_i & ~redirect_i;
  assign pop         = ~empty & ~stall_i & ~redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ISSUE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE:   if (fire) state_d = redirect_i ? DRAIN : WAIT;
      WAIT:    if (imem_rvalid_i) state_d = ISSUE;
               else if (redirect_i) state_d = DRAIN;
      DRAIN:   if (imem_rvalid_i) state_d = ISSUE;
      default: state_d = ISSUE;
    endcase
  end

  // Nothing is outstanding in ISSUE, so FIFO occupancy alone gates the request.
  always_comb begin
    imem_req_o   = run_q && (state_q == ISSUE) && (count_q < 2'd2);
    imem_addr_o  = fetch_pc_q;
    inst_valid_o = ~empty;
    inst_o       = empty ? NOP_INST  : fifo_inst[rd_ptr_q];
    pc_o         = empty ? last_pc_q : fifo_pc[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      last_pc_q  <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      run_q <= 1'b1;
      if (redirect_i) fetch_pc_q <= redirect_pc;
      else if (fire)  fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
      if (fire) req_pc_q  <= fetch_pc_q;
      if (pop)  last_pc_q <= fifo_pc[rd_ptr_q];
      if (redirect_i) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // Storage is masked by count_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]   <= req_pc_q;
      fifo_inst[wr_ptr_q] <= imem_rdata_i;
    end
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_o  <= 32'd0;
      flush_cnt_o  <= 32'd0;
      bubble_cnt_o <= 32'd0;
    end else begin
      if (push)                      fetch_cnt_o  <= fetch_cnt_o + 32'd1;
      if (redirect_i)                flush_cnt_o  <= flush_cnt_o + 32'd1;
      if (~inst_valid_o & ~stall_i)  bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule
